// File: rtl/dpe_pkg.sv
// Shared widths, address encodings and beat payload for the DPE datapath.
package dpe_pkg;

    localparam int unsigned DPE_DATA_W = 64;
    localparam int unsigned DPE_KEEP_W = DPE_DATA_W / 8;
    localparam int unsigned DPE_SRC_W  = 3;
    localparam int unsigned DPE_DST_W  = 3;
    localparam int unsigned DPE_PORTS  = 5;

    localparam logic [DPE_DST_W-1:0] DPE_ADDR_CPU   = 3'd0;
    localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_1 = 3'd1;
    localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_2 = 3'd2;
    localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_3 = 3'd3;
    localparam logic [DPE_DST_W-1:0] DPE_ADDR_ETH_4 = 3'd4;
    localparam logic [DPE_DST_W-1:0] DPE_ADDR_BCAST = 3'd7;

    // One stream beat, everything except the handshake.
    typedef struct packed {
        logic [DPE_DATA_W-1:0] tdata;
        logic [DPE_KEEP_W-1:0] tkeep;
        logic                  tlast;
        logic                  tuser_bypass_all;
        logic                  tuser_bypass_stage;
        logic [DPE_SRC_W-1:0]  tuser_src;
        logic [DPE_DST_W-1:0]  tuser_dst;
    } dpe_beat_t;

endpackage

// File: rtl/dpe_demultiplexer_if.sv
// AXI-Stream-like DPE stream; master drives payload and tvalid, slave drives tready.
interface dpe_if;
    import dpe_pkg::*;

    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DPE_KEEP_W-1:0] tkeep;
    logic [DPE_DATA_W-1:0] tdata;
    logic                  tuser_bypass_all;
    logic                  tuser_bypass_stage;
    logic [DPE_SRC_W-1:0]  tuser_src;
    logic [DPE_DST_W-1:0]  tuser_dst;

    modport master (
        output tvalid, tlast, tkeep, tdata,
        output tuser_bypass_all, tuser_bypass_stage, tuser_src, tuser_dst,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tkeep, tdata,
        input  tuser_bypass_all, tuser_bypass_stage, tuser_src, tuser_dst,
        output tready
    );

endinterface

// File: rtl/dpe_demultiplexer.sv
// Egress demultiplexer: steers whole packets to CPU / ETH1..4 (or all, for
// broadcast) through a one-beat holding register with per-port pending bits.
module dpe_demultiplexer
    import dpe_pkg::*;
(
    input  logic   sys_clk,
    input  logic   sys_rst,
    dpe_if.slave   from_dpe,
    dpe_if.master  to_cpu,
    dpe_if.master  to_eth_1,
    dpe_if.master  to_eth_2,
    dpe_if.master  to_eth_3,
    dpe_if.master  to_eth_4
);

    localparam int unsigned NP = DPE_PORTS;

    // Holding register and packet state; port bits ordered {eth_4..eth_1, cpu}
    logic          r_hold_valid;
    logic [NP-1:0] r_pending;
    logic [NP-1:0] r_route;
    logic          r_in_pkt;
    dpe_beat_t     r_beat;

    logic [NP-1:0] w_route_dec;
    logic [NP-1:0] w_route;
    logic [NP-1:0] w_out_ready;
    logic [NP-1:0] w_pending_nxt;
    logic          w_done;
    logic          w_in_ready;
    logic          w_accept;
    dpe_beat_t     w_in_beat;

    // Destination decode; unknown encodings map to an empty mask (drop)
    always_comb begin
        w_route_dec = '0;
        case (from_dpe.tuser_dst)
            DPE_ADDR_CPU:   w_route_dec = 5'b00001;
            DPE_ADDR_ETH_1: w_route_dec = 5'b00010;
            DPE_ADDR_ETH_2: w_route_dec = 5'b00100;
            DPE_ADDR_ETH_3: w_route_dec = 5'b01000;
            DPE_ADDR_ETH_4: w_route_dec = 5'b10000;
            DPE_ADDR_BCAST: w_route_dec = 5'b11111;
            default:        w_route_dec = '0;
        endcase
    end

    // Only the first beat of a packet decides where the whole packet goes
    assign w_route = r_in_pkt ? r_route : w_route_dec;

    assign w_in_beat = {from_dpe.tdata, from_dpe.tkeep, from_dpe.tlast,
                        from_dpe.tuser_bypass_all, from_dpe.tuser_bypass_stage,
                        from_dpe.tuser_src, from_dpe.tuser_dst};

    assign w_out_ready   = {to_eth_4.tready, to_eth_3.tready, to_eth_2.tready,
                            to_eth_1.tready, to_cpu.tready};
    assign w_pending_nxt = r_pending & ~w_out_ready;
    assign w_done        = r_hold_valid && (w_pending_nxt == '0);

    // Ready when empty or when the slowest remaining port takes the beat now
    assign w_in_ready      = !r_hold_valid || w_done;
    assign w_accept        = from_dpe.tvalid && w_in_ready;
    assign from_dpe.tready = w_in_ready;

    // Holding register: reload on accept, otherwise retire ports as they take the beat
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hold_valid <= 1'b0;
            r_pending    <= '0;
            r_route      <= '0;
            r_in_pkt     <= 1'b0;
            r_beat       <= '0;
        end else if (w_accept) begin
            r_hold_valid <= (w_route != '0);
            r_pending    <= w_route;
            r_beat       <= w_in_beat;
            r_in_pkt     <= !from_dpe.tlast;
            if (!r_in_pkt) begin
                r_route <= w_route_dec;
            end
        end else if (r_hold_valid) begin
            r_pending <= w_pending_nxt;
            if (w_done) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Output fan-out straight from the holding register
    assign to_cpu.tvalid             = r_hold_valid & r_pending[0];
    assign to_cpu.tlast              = r_beat.tlast;
    assign to_cpu.tkeep              = r_beat.tkeep;
    assign to_cpu.tdata              = r_beat.tdata;
    assign to_cpu.tuser_bypass_all   = r_beat.tuser_bypass_all;
    assign to_cpu.tuser_bypass_stage = r_beat.tuser_bypass_stage;
    assign to_cpu.tuser_src          = r_beat.tuser_src;
    assign to_cpu.tuser_dst          = r_beat.tuser_dst;

    assign to_eth_1.tvalid             = r_hold_valid & r_pending[1];
    assign to_eth_1.tlast              = r_beat.tlast;
    assign to_eth_1.tkeep              = r_beat.tkeep;
    assign to_eth_1.tdata              = r_beat.tdata;
    assign to_eth_1.tuser_bypass_all   = r_beat.tuser_bypass_all;
    assign to_eth_1.tuser_bypass_stage = r_beat.tuser_bypass_stage;
    assign to_eth_1.tuser_src          = r_beat.tuser_src;
    assign to_eth_1.tuser_dst          = r_beat.tuser_dst;

    assign to_eth_2.tvalid             = r_hold_valid & r_pending[2];
    assign to_eth_2.tlast              = r_beat.tlast;
    assign to_eth_2.tkeep              = r_beat.tkeep;
    assign to_eth_2.tdata              = r_beat.tdata;
    assign to_eth_2.tuser_bypass_all   = r_beat.tuser_bypass_all;
    assign to_eth_2.tuser_bypass_stage = r_beat.tuser_bypass_stage;
    assign to_eth_2.tuser_src          = r_beat.tuser_src;
    assign to_eth_2.tuser_dst          = r_beat.tuser_dst;

    assign to_eth_3.tvalid             = r_hold_valid & r_pending[3];
    assign to_eth_3.tlast              = r_beat.tlast;
    assign to_eth_3.tkeep              = r_beat.tkeep;
    assign to_eth_3.tdata              = r_beat.tdata;
    assign to_eth_3.tuser_bypass_all   = r_beat.tuser_bypass_all;
    assign to_eth_3.tuser_bypass_stage = r_beat.tuser_bypass_stage;
    assign to_eth_3.tuser_src          = r_beat.tuser_src;
    assign to_eth_3.tuser_dst          = r_beat.tuser_dst;

    assign to_eth_4.tvalid             = r_hold_valid & r_pending[4];
    assign to_eth_4.tlast              = r_beat.tlast;
    assign to_eth_4.tkeep              = r_beat.tkeep;
    assign to_eth_4.tdata              = r_beat.tdata;
    assign to_eth_4.tuser_bypass_all   = r_beat.tuser_bypass_all;
    assign to_eth_4.tuser_bypass_stage = r_beat.tuser_bypass_stage;
    assign to_eth_4.tuser_src          = r_beat.tuser_src;
    assign to_eth_4.tuser_dst          = r_beat.tuser_dst;

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// Bench for dpe_demultiplexer: directed scenarios plus random traffic against
// per-port expected-beat queues.
module tb_dpe_demultiplexer;
    import dpe_pkg::*;

    localparam int unsigned NP = 5;
    localparam logic [DPE_DST_W-1:0] DST_BAD = 3'd5;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    dpe_if from_dpe ();
    dpe_if to_cpu   ();
    dpe_if to_eth_1 ();
    dpe_if to_eth_2 ();
    dpe_if to_eth_3 ();
    dpe_if to_eth_4 ();

    dpe_demultiplexer u_dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .from_dpe (from_dpe),
        .to_cpu   (to_cpu),
        .to_eth_1 (to_eth_1),
        .to_eth_2 (to_eth_2),
        .to_eth_3 (to_eth_3),
        .to_eth_4 (to_eth_4)
    );

    // Input driver signals
    logic      in_valid = 1'b0;
    dpe_beat_t in_beat  = '0;
    assign from_dpe.tvalid             = in_valid;
    assign from_dpe.tdata              = in_beat.tdata;
    assign from_dpe.tkeep              = in_beat.tkeep;
    assign from_dpe.tlast              = in_beat.tlast;
    assign from_dpe.tuser_bypass_all   = in_beat.tuser_bypass_all;
    assign from_dpe.tuser_bypass_stage = in_beat.tuser_bypass_stage;
    assign from_dpe.tuser_src          = in_beat.tuser_src;
    assign from_dpe.tuser_dst          = in_beat.tuser_dst;

    // Output ready generation: 0 = all high, 1 = random, 2 = fixed toggle pattern
    logic [NP-1:0] out_rdy     = '1;
    logic [NP-1:0] rdy_force_lo = '0;
    int            rdy_mode    = 0;
    int            pat_cnt     = 0;
    assign to_cpu.tready   = out_rdy[0];
    assign to_eth_1.tready = out_rdy[1];
    assign to_eth_2.tready = out_rdy[2];
    assign to_eth_3.tready = out_rdy[3];
    assign to_eth_4.tready = out_rdy[4];

    logic [NP-1:0] o_valid;
    dpe_beat_t     o_beat [NP];
    assign o_valid = {to_eth_4.tvalid, to_eth_3.tvalid, to_eth_2.tvalid, to_eth_1.tvalid, to_cpu.tvalid};
    assign o_beat[0] = {to_cpu.tdata, to_cpu.tkeep, to_cpu.tlast, to_cpu.tuser_bypass_all,
                        to_cpu.tuser_bypass_stage, to_cpu.tuser_src, to_cpu.tuser_dst};
    assign o_beat[1] = {to_eth_1.tdata, to_eth_1.tkeep, to_eth_1.tlast, to_eth_1.tuser_bypass_all,
                        to_eth_1.tuser_bypass_stage, to_eth_1.tuser_src, to_eth_1.tuser_dst};
    assign o_beat[2] = {to_eth_2.tdata, to_eth_2.tkeep, to_eth_2.tlast, to_eth_2.tuser_bypass_all,
                        to_eth_2.tuser_bypass_stage, to_eth_2.tuser_src, to_eth_2.tuser_dst};
    assign o_beat[3] = {to_eth_3.tdata, to_eth_3.tkeep, to_eth_3.tlast, to_eth_3.tuser_bypass_all,
                        to_eth_3.tuser_bypass_stage, to_eth_3.tuser_src, to_eth_3.tuser_dst};
    assign o_beat[4] = {to_eth_4.tdata, to_eth_4.tkeep, to_eth_4.tlast, to_eth_4.tuser_bypass_all,
                        to_eth_4.tuser_bypass_stage, to_eth_4.tuser_src, to_eth_4.tuser_dst};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] dst_to_ports(input logic [DPE_DST_W-1:0] dst);
        case (dst)
            DPE_ADDR_CPU:   return 5'b00001;
            DPE_ADDR_ETH_1: return 5'b00010;
            DPE_ADDR_ETH_2: return 5'b00100;
            DPE_ADDR_ETH_3: return 5'b01000;
            DPE_ADDR_ETH_4: return 5'b10000;
            DPE_ADDR_BCAST: return 5'b11111;
            default:        return 5'b00000;
        endcase
    endfunction

    function automatic logic pat_level(input int c);
        return !((c == 7) || (c >= 12 && c <= 14) || (c >= 19 && c <= 20) || (c >= 27 && c <= 28));
    endfunction

    always @(posedge sys_clk) begin
        logic [NP-1:0] base;
        #2;
        case (rdy_mode)
            1:       base = NP'($urandom) | NP'($urandom);
            2:       base = pat_level(pat_cnt) ? '1 : '0;
            default: base = '1;
        endcase
        out_rdy = base & ~rdy_force_lo;
        pat_cnt++;
    end

    // Reference model: packets go whole to the ports named by their first beat
    dpe_beat_t exp_q [NP][$];
    logic          m_in_pkt = 1'b0;
    logic [NP-1:0] m_route  = '0;
    int            delivered [NP];
    int            stalls = 0;
    logic          prev_stall [NP];
    dpe_beat_t     prev_beat  [NP];

    initial begin
        for (int p = 0; p < NP; p++) begin
            delivered[p]  = 0;
            prev_stall[p] = 1'b0;
            prev_beat[p]  = '0;
        end
    end

    always @(negedge sys_clk) begin
        dpe_beat_t     e;
        logic [NP-1:0] rt;
        if (sys_rst) begin
            for (int p = 0; p < NP; p++) begin
                exp_q[p].delete();
                prev_stall[p] = 1'b0;
            end
            m_in_pkt = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (prev_stall[p]) begin
                    check($sformatf("stable_valid[%0d]", p), 128'(o_valid[p]), 128'(1));
                    check($sformatf("stable_data[%0d]", p), 128'(o_beat[p]), 128'(prev_beat[p]));
                end
                if (o_valid[p]) begin
                    check($sformatf("expected_beat[%0d]", p), 128'(exp_q[p].size() != 0), 128'(1));
                    if (out_rdy[p] && exp_q[p].size() != 0) begin
                        e = exp_q[p].pop_front();
                        check($sformatf("beat[%0d]", p), 128'(o_beat[p]), 128'(e));
                        delivered[p]++;
                    end
                end
                prev_stall[p] = o_valid[p] & ~out_rdy[p];
                prev_beat[p]  = o_beat[p];
            end
            if (in_valid) begin
                if (from_dpe.tready) begin
                    rt = m_in_pkt ? m_route : dst_to_ports(in_beat.tuser_dst);
                    m_route = rt;
                    for (int p = 0; p < NP; p++)
                        if (rt[p]) exp_q[p].push_back(in_beat);
                    m_in_pkt = !in_beat.tlast;
                end else begin
                    stalls++;
                end
            end
        end
    end

    // Sends beats [0, stop_after) of a len-beat packet; called and returns at posedge+1
    task automatic send_pkt(input logic [DPE_DST_W-1:0] dst, input logic [DPE_DST_W-1:0] dst_late,
                            input int len, input logic [63:0] base, input int gap_pct,
                            input int stop_after);
        logic acc;
        int   t;
        for (int i = 0; i < len && i < stop_after; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge sys_clk); #1;
            end
            in_beat.tdata              = base + 64'(i);
            in_beat.tkeep              = DPE_KEEP_W'($urandom);
            in_beat.tlast              = (i == len - 1);
            in_beat.tuser_bypass_all   = 1'($urandom);
            in_beat.tuser_bypass_stage = 1'($urandom);
            in_beat.tuser_src          = DPE_SRC_W'($urandom);
            in_beat.tuser_dst          = (i == 0) ? dst : dst_late;
            in_valid                   = 1'b1;
            t = 0;
            do begin
                @(negedge sys_clk);
                acc = from_dpe.tready;
                @(posedge sys_clk); #1;
                t++;
            end while (!acc && t < 200);
            if (!acc) check("accept_timeout", 128'(acc), 128'(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        int left;
        do begin
            left = 0;
            for (int p = 0; p < NP; p++) left += exp_q[p].size();
            if (left != 0) begin
                @(posedge sys_clk);
                t++;
            end
        end while (left != 0 && t < 400);
        check("drain_left", 128'(left), 128'(0));
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    int base_cnt [NP];

    task automatic snap();
        for (int p = 0; p < NP; p++) base_cnt[p] = delivered[p];
    endtask

    task automatic check_deltas(input string tag, input int d0, input int d1, input int d2,
                                input int d3, input int d4);
        int exp_d [NP];
        exp_d = '{d0, d1, d2, d3, d4};
        for (int p = 0; p < NP; p++)
            check($sformatf("%s_count[%0d]", tag, p), 128'(delivered[p] - base_cnt[p]), 128'(exp_d[p]));
    endtask

    initial begin
        logic [DPE_DST_W-1:0] d, dl;

        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("reset_tready", 128'(from_dpe.tready), 128'(1));
        check("reset_tvalid", 128'(o_valid), 128'(0));
        check("reset_tdata", 128'(o_beat[0]), 128'(0));
        @(posedge sys_clk); #1;

        // Unicast CPU, 6 beats, all ready
        snap(); stalls = 0;
        send_pkt(DPE_ADDR_CPU, DPE_ADDR_CPU, 6, 64'h1, 0, 6);
        wait_drain();
        check("cpu_stalls", 128'(stalls), 128'(0));
        check_deltas("cpu", 6, 0, 0, 0, 0);

        // Unicast ETH1..4 back-to-back under the toggled-ready pattern
        snap();
        pat_cnt = 0; rdy_mode = 2;
        send_pkt(DPE_ADDR_ETH_1, DPE_ADDR_ETH_1, 4, 64'h100, 0, 4);
        send_pkt(DPE_ADDR_ETH_2, DPE_ADDR_ETH_2, 5, 64'h200, 0, 5);
        send_pkt(DPE_ADDR_ETH_3, DPE_ADDR_ETH_3, 4, 64'h300, 0, 4);
        send_pkt(DPE_ADDR_ETH_4, DPE_ADDR_ETH_4, 4, 64'h400, 0, 4);
        wait_drain();
        rdy_mode = 0;
        check_deltas("eth", 0, 4, 5, 4, 4);

        // Broadcast with ETH_2 held off for three cycles
        snap(); stalls = 0;
        fork
            send_pkt(DPE_ADDR_BCAST, DPE_ADDR_BCAST, 5, 64'h33, 0, 5);
            begin
                repeat (2) @(posedge sys_clk);
                #1 rdy_force_lo = 5'b00100;
                repeat (3) @(posedge sys_clk);
                #1 rdy_force_lo = '0;
            end
        join
        wait_drain();
        check("bcast_stalls", 128'(stalls), 128'(3));
        check_deltas("bcast", 5, 5, 5, 5, 5);

        // Destination changes after SOP: packet stays on CPU
        snap();
        send_pkt(DPE_ADDR_CPU, DPE_ADDR_ETH_3, 4, 64'h500, 0, 4);
        wait_drain();
        check_deltas("midchg", 4, 0, 0, 0, 0);

        // Invalid destination is swallowed without stalling, next packet routes
        snap(); stalls = 0;
        send_pkt(DST_BAD, DST_BAD, 4, 64'h600, 0, 4);
        wait_drain();
        check("drop_stalls", 128'(stalls), 128'(0));
        check_deltas("drop", 0, 0, 0, 0, 0);
        snap();
        send_pkt(DPE_ADDR_ETH_2, DPE_ADDR_ETH_2, 3, 64'h680, 0, 3);
        wait_drain();
        check_deltas("after_drop", 0, 0, 3, 0, 0);

        // Reset mid-packet while a beat is held, then a fresh packet
        send_pkt(DPE_ADDR_ETH_1, DPE_ADDR_ETH_1, 5, 64'h700, 0, 2);
        sys_rst = 1'b1;
        rdy_force_lo = '1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_tvalid", 128'(o_valid), 128'(0));
        check("midrst_tready", 128'(from_dpe.tready), 128'(1));
        @(posedge sys_clk); #1;
        rdy_force_lo = '0;
        snap();
        send_pkt(DPE_ADDR_ETH_4, DPE_ADDR_ETH_4, 3, 64'h780, 0, 3);
        wait_drain();
        check_deltas("after_rst", 0, 0, 0, 0, 3);

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            d  = DPE_DST_W'($urandom_range(7));
            dl = ($urandom_range(1) == 0) ? d : DPE_DST_W'($urandom_range(7));
            send_pkt(d, dl, int'($urandom_range(1, 6)), {32'($urandom), 32'($urandom)}, 20, 6);
        end
        rdy_mode = 0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
